// File: rtl/ipm2l_hsstlp_pll_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// ipm2l_hsstlp_pll_seq_ctrl_if
//
// Purpose: handshake bundle between the PLL bring-up sequencer and the
// HSSTLP PLL reset block. Signal names follow the sequencer's view
// (i_ = into the sequencer, o_ = out of the sequencer).
//
// Signals:
//   o_pll_rst_0/1     active-high reset request per PLL
//   o_wtchdg_clr_0/1  single-cycle watchdog clear per PLL
//   i_pll_done_0/1    per-PLL done flag from the reset block
//   i_wtchdg_st_0/1   per-PLL watchdog status, bit 1 = watchdog fired
//
// Modports:
//   master  sequencer side (drives resets and clears)
//   slave   PLL reset block side (drives done and watchdog status)
// ---------------------------------------------------------------------------
interface ipm2l_hsstlp_pll_seq_ctrl_if;
    logic       o_pll_rst_0;
    logic       o_pll_rst_1;
    logic       o_wtchdg_clr_0;
    logic       o_wtchdg_clr_1;
    logic       i_pll_done_0;
    logic       i_pll_done_1;
    logic [1:0] i_wtchdg_st_0;
    logic [1:0] i_wtchdg_st_1;

    modport master (
        output o_pll_rst_0, o_pll_rst_1, o_wtchdg_clr_0, o_wtchdg_clr_1,
        input  i_pll_done_0, i_pll_done_1, i_wtchdg_st_0, i_wtchdg_st_1
    );

    modport slave (
        input  o_pll_rst_0, o_pll_rst_1, o_wtchdg_clr_0, o_wtchdg_clr_1,
        output i_pll_done_0, i_pll_done_1, i_wtchdg_st_0, i_wtchdg_st_1
    );
endinterface

// File: rtl/ipm2l_hsstlp_pll_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ipm2l_hsstlp_pll_seq_ctrl
//
// Purpose: bring-up sequencer for the two HSSTLP PLL reset channels. PLL0 is
// held in reset and awaited first, then PLL1, so the PLLs never calibrate at
// the same time. Watchdog trips (and, optionally, done-wait timeouts) retry
// the current PLL up to MAX_RETRY times before latching FAIL. Aggregate
// done/fail status goes to the lane reset logic.
//
// Ports:
//   clk          free-running clock
//   rst_n        synchronous active-low reset
//   i_restart    single-cycle pulse, restarts the whole sequence
//   bus          PLL reset block handshake (master modport)
//   o_all_done   all configured PLLs done
//   o_fail       retry budget exhausted
//   o_retry_cnt  retries consumed by the PLL currently in sequence
//
// Configuration macro:
//   IPM2L_HSSTLP_PLL_SEQ_TIMEOUT_EN  when defined, WAITx runs a timeout
//   counter (TMO_CYC = FREE_CLOCK_FREQ*TIMEOUT_US) and a timeout is a retry
//   event. When undefined, WAITx waits indefinitely; only watchdog retries.
// ---------------------------------------------------------------------------
module ipm2l_hsstlp_pll_seq_ctrl #(
    parameter int FREE_CLOCK_FREQ = 100,
    parameter int PLL_NUMBER      = 1,
    parameter int RST_HOLD_US     = 1,
    parameter int TIMEOUT_US      = 10,
    parameter int MAX_RETRY       = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_restart,
    ipm2l_hsstlp_pll_seq_ctrl_if.master        bus,
    output logic                               o_all_done,
    output logic                               o_fail,
    output logic [2:0]                         o_retry_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST0,
        S_WAIT0,
        S_RST1,
        S_WAIT1,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [15:0] HOLD_LAST = 16'(FREE_CLOCK_FREQ * RST_HOLD_US - 1);
    localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRY);
    localparam bit          TWO_PLL   = (PLL_NUMBER == 2);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_retry_cnt;

    state_t      w_next;
    logic        w_done_0;
    logic        w_done_1;
    logic        w_wd_0;
    logic        w_wd_1;
    logic        w_tmo;
    logic        w_cnt_run;
    logic        w_retry_0;
    logic        w_retry_1;
    logic        w_budget_left;
    logic        w_done_evt;
    logic        w_unused_wd;

    // With a single PLL the channel-1 inputs are forced inactive so WAIT1 and
    // the DONE lock check can never see them.
    assign w_done_0 = bus.i_pll_done_0;
    assign w_done_1 = TWO_PLL && bus.i_pll_done_1;
    assign w_wd_0   = bus.i_wtchdg_st_0[1];
    assign w_wd_1   = TWO_PLL && bus.i_wtchdg_st_1[1];

    // Only the "fired" bit of the watchdog status matters here.
    assign w_unused_wd = bus.i_wtchdg_st_0[0] ^ bus.i_wtchdg_st_1[0];

`ifdef IPM2L_HSSTLP_PLL_SEQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(FREE_CLOCK_FREQ * TIMEOUT_US - 1);
    assign w_tmo     = (r_cnt == TMO_LAST);
    assign w_cnt_run = r_state inside {S_RST0, S_RST1, S_WAIT0, S_WAIT1};
`else
    assign w_tmo     = 1'b0;
    assign w_cnt_run = r_state inside {S_RST0, S_RST1};
`endif

    // A watchdog trip and a timeout in the same cycle form a single event;
    // a done flag in that cycle wins over both.
    assign w_retry_0     = (r_state == S_WAIT0) && !w_done_0 && (w_wd_0 || w_tmo);
    assign w_retry_1     = (r_state == S_WAIT1) && !w_done_1 && (w_wd_1 || w_tmo);
    assign w_budget_left = (r_retry_cnt < RETRY_MAX);
    assign w_done_evt    = ((r_state == S_WAIT0) && w_done_0) ||
                           ((r_state == S_WAIT1) && w_done_1);

    always_comb begin
        // NOTE: default assignment first so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        if (i_restart) begin
            w_next = S_RST0;
        end else begin
            case (r_state)
                S_IDLE:  w_next = S_RST0;
                S_RST0:  if (r_cnt == HOLD_LAST) w_next = S_WAIT0;
                S_WAIT0: begin
                    if (w_done_0)       w_next = TWO_PLL ? S_RST1 : S_DONE;
                    else if (w_retry_0) w_next = w_budget_left ? S_RST0 : S_FAIL;
                end
                S_RST1:  if (r_cnt == HOLD_LAST) w_next = S_WAIT1;
                S_WAIT1: begin
                    if (w_done_1)       w_next = S_DONE;
                    else if (w_retry_1) w_next = w_budget_left ? S_RST1 : S_FAIL;
                end
                // Lock loss: PLL0 first, and re-sequencing PLL0 also re-runs PLL1.
                S_DONE: begin
                    if (!w_done_0)                 w_next = S_RST0;
                    else if (TWO_PLL && !w_done_1) w_next = S_RST1;
                end
                S_FAIL:  w_next = S_FAIL;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only; rst_n is not in the sensitivity list.
        if (!rst_n) begin
            r_state            <= S_IDLE;
            r_cnt              <= '0;
            r_retry_cnt        <= '0;
            bus.o_pll_rst_0    <= 1'b1;
            bus.o_pll_rst_1    <= 1'b1;
            bus.o_wtchdg_clr_0 <= 1'b0;
            bus.o_wtchdg_clr_1 <= 1'b0;
            o_all_done         <= 1'b0;
            o_fail             <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next;

            // Shared hold/timeout counter restarts on every state change and
            // on a restart that re-enters RST0 from RST0.
            if (i_restart || (w_next != r_state)) begin
                r_cnt <= '0;
            end else if (w_cnt_run) begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (i_restart || w_done_evt) begin
                r_retry_cnt <= '0;
            end else if ((w_retry_0 || w_retry_1) && w_budget_left) begin
                r_retry_cnt <= r_retry_cnt + 3'd1;
            end

            bus.o_wtchdg_clr_0 <= !i_restart && w_retry_0;
            bus.o_wtchdg_clr_1 <= !i_restart && w_retry_1;

            // Outputs follow the state being entered, so they change on the
            // same edge as the state register.
            bus.o_pll_rst_0 <= w_next inside {S_IDLE, S_RST0, S_FAIL};
            bus.o_pll_rst_1 <= !TWO_PLL || !(w_next inside {S_WAIT1, S_DONE});
            o_all_done      <= (w_next == S_DONE);
            o_fail          <= (w_next == S_FAIL);
        end
    end

    assign o_retry_cnt = r_retry_cnt;

endmodule
